// File: rtl/pipeline_hazard_ctrl_if.sv
// Stall/flush control bundle between the decode-side hazard sequencer and the pipeline.
// HAZARD_STATS_EN adds the StallCycles/FreezeCycles counters.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] IdRs;
  logic [REG_ADDR_W-1:0] IdRt;
  logic                  IdUsesRt;
  logic                  IdMulDivStart;
  logic                  IdReadsHiLo;
  logic                  ExMemRead;
  logic [REG_ADDR_W-1:0] ExRt;
  logic                  ExBranchTaken;
  logic                  MemReq;
  logic                  MemReady;
  logic                  PcEn;
  logic                  IfIdEn;
  logic                  IdExEn;
  logic                  ExMemEn;
  logic                  MemWbEn;
  logic                  IfIdFlush;
  logic                  IdExFlush;
  logic                  MulDivBusy;
`ifdef HAZARD_STATS_EN
  logic [31:0]           StallCycles;
  logic [31:0]           FreezeCycles;
`endif

  modport slave (
    input  IdRs, IdRt, IdUsesRt, IdMulDivStart, IdReadsHiLo,
    input  ExMemRead, ExRt, ExBranchTaken, MemReq, MemReady,
`ifdef HAZARD_STATS_EN
    output StallCycles, FreezeCycles,
`endif
    output PcEn, IfIdEn, IdExEn, ExMemEn, MemWbEn, IfIdFlush, IdExFlush, MulDivBusy
  );

  modport master (
    output IdRs, IdRt, IdUsesRt, IdMulDivStart, IdReadsHiLo,
    output ExMemRead, ExRt, ExBranchTaken, MemReq, MemReady,
`ifdef HAZARD_STATS_EN
    input  StallCycles, FreezeCycles,
`endif
    input  PcEn, IfIdEn, IdExEn, ExMemEn, MemWbEn, IfIdFlush, IdExFlush, MulDivBusy
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use, mult/div occupancy,
// data-memory wait states and taken branches. Optional counters under HAZARD_STATS_EN.
module pipeline_hazard_ctrl #(
  parameter int MULDIV_CYCLES = 32,
  parameter int REG_ADDR_W    = 5
) (
  input logic                    Clk,
  input logic                    Rst_n,
  pipeline_hazard_ctrl_if.slave  hz
);
  typedef enum logic [1:0] {RUN, MEM_WAIT} state_t;

  state_t     state;
  logic [7:0] md_cnt;
  logic       freeze, load_use, md_haz, issue;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;

  assign freeze   = hz.MemReq & ~hz.MemReady;
  assign load_use = hz.ExMemRead & (hz.ExRt != '0) &
                    ((hz.ExRt == hz.IdRs) | (hz.IdUsesRt & (hz.ExRt == hz.IdRt)));
  assign md_haz   = (md_cnt != 8'd0) & (hz.IdReadsHiLo | hz.IdMulDivStart);

  // Reset clocks bubbles in; otherwise freeze > branch squash > ID stall.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!Rst_n) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (freeze) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (hz.ExBranchTaken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (md_haz | load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign issue = hz.IdMulDivStart & id_ex_en & ~id_ex_flush;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= RUN;
      md_cnt <= 8'd0;
    end else begin
      case (state)
        RUN:      if (freeze) state <= MEM_WAIT;
        MEM_WAIT: if (hz.MemReady || !hz.MemReq) state <= RUN;
        default:  state <= RUN;
      endcase
      if (issue)                md_cnt <= 8'(MULDIV_CYCLES);
      else if (md_cnt != 8'd0)  md_cnt <= md_cnt - 8'd1;
    end
  end

  assign hz.PcEn       = pc_en;
  assign hz.IfIdEn     = if_id_en;
  assign hz.IdExEn     = id_ex_en;
  assign hz.ExMemEn    = ex_mem_en;
  assign hz.MemWbEn    = mem_wb_en;
  assign hz.IfIdFlush  = if_id_flush;
  assign hz.IdExFlush  = id_ex_flush;
  assign hz.MulDivBusy = (md_cnt != 8'd0);

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, freeze_cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (!pc_en && stall_cnt != '1)  stall_cnt  <= stall_cnt + 32'd1;
      if (freeze && freeze_cnt != '1) freeze_cnt <= freeze_cnt + 32'd1;
    end
  end

  assign hz.StallCycles  = stall_cnt;
  assign hz.FreezeCycles = freeze_cnt;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: each cycle's expected control word is queued with its stimulus
// and popped against the DUT outputs at the falling edge.
module tb_pipeline_hazard_ctrl;
  localparam int MD = 4;

  // Expected word layout: {PcEn,IfIdEn,IdExEn,ExMemEn,MemWbEn,IfIdFlush,IdExFlush,MulDivBusy}
  localparam logic [7:0] RUN  = 8'hF8;
  localparam logic [7:0] RUNB = 8'hF9;
  localparam logic [7:0] STLB = 8'h3B;
  localparam logic [7:0] STL  = 8'h3A;
  localparam logic [7:0] FRZ  = 8'h00;
  localparam logic [7:0] FRZB = 8'h01;
  localparam logic [7:0] FLS  = 8'hFE;
  localparam logic [7:0] FLSB = 8'hFF;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs, rt;
    logic       urt, mds, hilo, lr;
    logic [4:0] ert;
    logic       br, mreq, mrdy;
  } stim_t;

  logic Clk, Rst_n;
  int   total, bad;
  logic [7:0] sb[$];
  logic [7:0] got, want;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5)) bus();
  pipeline_hazard_ctrl #(.MULDIV_CYCLES(MD), .REG_ADDR_W(5)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .hz(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic stim_t mk(logic rst, logic [4:0] rs, logic [4:0] rt, logic urt,
                               logic mds, logic hilo, logic lr, logic [4:0] ert,
                               logic br, logic mreq, logic mrdy);
    stim_t s;
    s.rst = rst; s.rs = rs; s.rt = rt; s.urt = urt; s.mds = mds; s.hilo = hilo;
    s.lr = lr; s.ert = ert; s.br = br; s.mreq = mreq; s.mrdy = mrdy;
    return s;
  endfunction

  function automatic logic [7:0] obs();
    return {bus.PcEn, bus.IfIdEn, bus.IdExEn, bus.ExMemEn, bus.MemWbEn,
            bus.IfIdFlush, bus.IdExFlush, bus.MulDivBusy};
  endfunction

  task automatic apply(input stim_t s, input logic [7:0] exp);
    Rst_n             = ~s.rst;
    bus.IdRs          = s.rs;
    bus.IdRt          = s.rt;
    bus.IdUsesRt      = s.urt;
    bus.IdMulDivStart = s.mds;
    bus.IdReadsHiLo   = s.hilo;
    bus.ExMemRead     = s.lr;
    bus.ExRt          = s.ert;
    bus.ExBranchTaken = s.br;
    bus.MemReq        = s.mreq;
    bus.MemReady      = s.mrdy;
    sb.push_back(exp);
  endtask

  task automatic test_reset();
    stim_t s[2];
    logic [7:0] e[2];
    s = '{mk(1,0,0,0,0,0,0,0,0,0,0), mk(1,5,0,0,1,0,1,5,0,1,0)};
    e = '{FLS, FLS};
    for (int i = 0; i < 2; i++) begin
      apply(s[i], e[i]);
      @(negedge Clk);
      got = obs(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL reset[%0d] got=%h want=%h", i, got, want); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t s[10];
    logic [7:0] e[10];
    s = '{mk(0,5,0,0,0,0,1,5,0,0,0), mk(0,5,0,0,0,0,0,0,0,0,0),
          mk(0,3,7,1,0,0,1,7,0,0,0), mk(0,3,7,0,0,0,1,7,0,0,0),
          mk(0,0,0,1,0,0,1,0,0,0,0), mk(0,4,0,0,0,0,1,5,0,0,0),
          mk(0,5,0,0,0,0,1,5,0,0,0), mk(0,6,0,0,0,0,0,0,0,0,0),
          mk(0,6,0,0,0,0,1,6,0,0,0), mk(0,1,0,0,0,0,0,0,0,0,0)};
    e = '{STL, RUN, STL, RUN, RUN, RUN, STL, RUN, STL, RUN};
    for (int i = 0; i < 10; i++) begin
      apply(s[i], e[i]);
      @(negedge Clk);
      got = obs(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL load_use[%0d] got=%h want=%h", i, got, want); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_muldiv();
    stim_t s[17];
    logic [7:0] e[17];
    stim_t idle, mds, hilo;
    idle = mk(0,0,0,0,0,0,0,0,0,0,0);
    mds  = mk(0,0,0,0,1,0,0,0,0,0,0);
    hilo = mk(0,0,0,0,0,1,0,0,0,0,0);
    s = '{mds, hilo, hilo, hilo, hilo, hilo,
          mds, mds, mds, mds, mds, mds,
          idle, idle, idle, idle, idle};
    e = '{RUN, STLB, STLB, STLB, STLB, RUN,
          RUN, STLB, STLB, STLB, STLB, RUN,
          RUNB, RUNB, RUNB, RUNB, RUN};
    for (int i = 0; i < 17; i++) begin
      apply(s[i], e[i]);
      @(negedge Clk);
      got = obs(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL muldiv[%0d] got=%h want=%h", i, got, want); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_freeze();
    stim_t s[14];
    logic [7:0] e[14];
    stim_t idle, frz, done;
    idle = mk(0,0,0,0,0,0,0,0,0,0,0);
    frz  = mk(0,0,0,0,0,0,0,0,0,1,0);
    done = mk(0,0,0,0,0,0,0,0,0,1,1);
    s = '{frz, frz, frz, done, idle,
          mk(0,0,0,0,1,0,0,0,0,0,0), frz, frz, done, idle, idle,
          mk(0,5,0,0,0,0,1,5,0,1,0), mk(0,5,0,0,0,0,1,5,0,0,0), idle};
    e = '{FRZ, FRZ, FRZ, RUN, RUN,
          RUN, FRZB, FRZB, RUNB, RUNB, RUN,
          FRZ, STL, RUN};
    for (int i = 0; i < 14; i++) begin
      apply(s[i], e[i]);
      @(negedge Clk);
      got = obs(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL freeze[%0d] got=%h want=%h", i, got, want); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_branch();
    stim_t s[12];
    logic [7:0] e[12];
    stim_t idle;
    idle = mk(0,0,0,0,0,0,0,0,0,0,0);
    s = '{mk(0,5,0,0,0,0,1,5,1,0,0), mk(0,0,0,0,1,0,0,0,1,0,0), idle,
          mk(0,5,0,0,0,0,1,5,1,1,0), mk(0,5,0,0,0,0,1,5,1,1,0),
          mk(0,5,0,0,0,0,1,5,1,1,1), idle,
          mk(0,0,0,0,1,0,0,0,0,0,0), mk(0,0,0,0,0,1,0,0,1,0,0), idle, idle, idle};
    e = '{FLS, FLS, RUN, FRZ, FRZ, FLS, RUN, RUN, FLSB, RUNB, RUNB, RUNB};
    for (int i = 0; i < 12; i++) begin
      apply(s[i], e[i]);
      @(negedge Clk);
      got = obs(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL branch[%0d] got=%h want=%h", i, got, want); end
      @(posedge Clk); #1;
    end
    // Drain the last busy cycle so the next scenario starts idle.
    apply(idle, RUN);
    @(negedge Clk);
    got = obs(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL branch_drain got=%h want=%h", got, want); end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_mid();
    stim_t s[6];
    logic [7:0] e[6];
    stim_t idle;
    idle = mk(0,0,0,0,0,0,0,0,0,0,0);
    s = '{mk(0,0,0,0,1,0,0,0,0,0,0), idle, idle,
          mk(1,0,0,0,0,0,0,0,0,0,0), idle, idle};
    e = '{RUN, RUNB, RUNB, FLS, RUN, RUN};
    for (int i = 0; i < 6; i++) begin
      apply(s[i], e[i]);
      @(negedge Clk);
      got = obs(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL reset_mid[%0d] got=%h want=%h", i, got, want); end
      @(posedge Clk); #1;
    end
`ifdef HAZARD_STATS_EN
    total++;
    if (bus.StallCycles !== 32'd0) begin bad++; $display("FAIL stall_cnt_reset got=%0d want=0", bus.StallCycles); end
    total++;
    if (bus.FreezeCycles !== 32'd0) begin bad++; $display("FAIL freeze_cnt_reset got=%0d want=0", bus.FreezeCycles); end
    bus.MemReq = 1'b1; bus.MemReady = 1'b0;
    @(posedge Clk); #1;
    bus.MemReq = 1'b0; bus.ExMemRead = 1'b1; bus.ExRt = 5'd9; bus.IdRs = 5'd9;
    @(posedge Clk); #1;
    bus.ExMemRead = 1'b0;
    total++;
    if (bus.StallCycles !== 32'd2) begin bad++; $display("FAIL stall_cnt got=%0d want=2", bus.StallCycles); end
    total++;
    if (bus.FreezeCycles !== 32'd1) begin bad++; $display("FAIL freeze_cnt got=%0d want=1", bus.FreezeCycles); end
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Rst_n = 1'b0;
    apply(mk(1,0,0,0,0,0,0,0,0,0,0), FLS);
    void'(sb.pop_front());
    @(posedge Clk); #1;
    test_reset();
    test_load_use();
    test_muldiv();
    test_freeze();
    test_branch();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
